timer_scheduler: RTL
====================

# timer_scheduler

Shares one 16-bit free-running timestamp timer between N_REQ requesters (producer/consumer sides of the GALS design). Arbitrates requests round-robin, issues a single-cycle enable to the timer, captures the returned count and hands it to the winning requester over a 4-phase req/ack handshake. Sits between the requester FSMs and the timer in the `clock_1` domain. Includes a response timeout so a stalled timer cannot hang the system.

## Interface
- N_REQ, 2, number of requesters (2..4)
- TIMEOUT, 4, cycles in WAIT without `t_valid` before error completion (1..15)

- clock_1  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester request level (4-phase)
- ack  output  N_REQ  per-requester acknowledge, one-hot or zero
- stamp  output  16  captured timestamp, valid while any `ack` bit is high
- err  output  1  high with `ack` when the transaction timed out
- gnt  output  N_REQ  one-hot current grant, zero in IDLE
- busy  output  1  high in any state other than IDLE
- t_en  output  1  enable to timer, single-cycle pulse
- t_valid  input  1  timer response strobe
- t_out  input  16  timer count, sampled when `t_valid`=1

## Operation
- FSM states: IDLE, EN, WAIT, RESP.
- IDLE: if any `req` bit high, pick winner round-robin, load `gnt`, go EN. Otherwise stay.
- Round-robin: search starts at index (last+1) mod N_REQ. `last` updates on each grant. After reset `last`=N_REQ-1, so index 0 wins first.
- EN: `t_en`=1 for exactly this cycle. Clear timeout counter. Go WAIT.
- WAIT: if `t_valid`=1, capture `t_out` into `stamp`, `err`=0, go RESP.
- WAIT timeout: the counter increments each WAIT cycle without `t_valid`. On reaching TIMEOUT: `stamp`=16'h0000, `err`=1, go RESP.
- RESP: `ack[gnt]`=1.
  - While `req[gnt]` stays 1, hold RESP.
  - When `req[gnt]`=0, go IDLE. `ack`, `gnt`, `err` clear on that transition; `stamp` keeps its last value.
- `t_valid` outside WAIT is ignored; `stamp` is not updated.
- A requester dropping `req` during EN/WAIT does not abort the transaction. RESP is still entered, and `ack` is high for one cycle.
- Requests from non-granted requesters are held off until IDLE. No preemption.
- `ack` bit i is asserted only if `gnt[i]`=1.
- Reset (`reset`=0, any time, including mid-transaction) forces:
  - state IDLE
  - `ack`=0, `gnt`=0, `t_en`=0, `err`=0, `busy`=0
  - `stamp`=16'h0000
  - `last`=N_REQ-1, timeout counter=0
- All outputs are registered.

## Timing
- Cycle k: `req` sampled high in IDLE.
- k+1: EN, `t_en`=1, `busy`=1, `gnt` valid.
- k+2: WAIT. The timer responds with `t_valid`=1 this cycle.
- k+3: RESP, `ack` and `stamp` valid.
- Latency from `req` sampled to `ack` high: 3 cycles with a one-cycle timer.
- Timeout path: `ack` with `err`=1 appears TIMEOUT+1 cycles after entering WAIT. For TIMEOUT=4, `ack` rises at k+7.
- `req[gnt]` sampled low in RESP at cycle m: `ack`=0 and IDLE at m+1.
  - Earliest next grant: sampled at m+1, `t_en` at m+2.
- Minimum transaction period per requester: 5 cycles (IDLE, EN, WAIT, RESP, RESP-release).
- Timer counter wraps 65535→0. The scheduler passes the value through unchanged; no wrap handling.

## Test plan
- Reset release, `req`=00, `t_valid`=0 for 10 cycles -> `ack`=00, `gnt`=00, `t_en`=0, `busy`=0, `stamp`=0000.
- Single request: `req[0]`=1, timer returns 16'h0005 one cycle after `t_en` -> `t_en` pulse 1 cycle at k+1, `ack`=01 and `stamp`=0005 at k+3, `err`=0. Drop `req` -> `ack`=00 next cycle.
- Both requests held continuously with handshakes completing -> grants alternate 0,1,0,1. Each requester receives strictly increasing stamps; no `ack`=11 ever.
- Timeout: `req[1]`=1, `t_valid` tied 0, TIMEOUT=4 -> `ack`=10, `err`=1, `stamp`=0000 at k+7.
- Wrap: timer returns 16'hFFFF then 16'h0000 -> stamps delivered as FFFF then 0000, `err`=0.
- Reset pulse asserted during WAIT with `req[0]`=1 -> all outputs zero immediately. After release the transaction restarts from IDLE with requester 0 winning.

Source files
------------

// File: rtl/timer_scheduler_if.sv
// Requester and timer signals of the shared timestamp scheduler.
// The scheduler is the slave side; requesters and timer drive the master side.
interface timer_scheduler_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] gnt;
    logic [15:0]      stamp;
    logic             err;
    logic             busy;
    logic             t_en;
    logic             t_valid;
    logic [15:0]      t_out;

    modport master (
        output req, t_valid, t_out,
        input  ack, gnt, stamp, err, busy, t_en
    );

    modport slave (
        input  req, t_valid, t_out,
        output ack, gnt, stamp, err, busy, t_en
    );
endinterface

// File: rtl/timer_scheduler.sv
// Round-robin sharing of one timestamp timer between N_REQ requesters,
// with a 4-phase req/ack return path and a response timeout.
module timer_scheduler #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 4
) (
    input logic              clock_1,
    input logic              reset,
    timer_scheduler_if.slave bus
);
    localparam int IW = (N_REQ > 2) ? 2 : 1;
    localparam logic [3:0] TMO = 4'(TIMEOUT);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        EN,
        WAIT,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [15:0]      stamp_q, stamp_d;
    logic             err_q, err_d;
    logic             t_en_q, t_en_d;
    logic             busy_q, busy_d;
    logic [IW-1:0]    last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick;
    logic             held;

    // Highest offset first so the closest requester after last wins.
    always_comb begin
        pick_idx = last_q;
        for (int i = N_REQ; i >= 1; i--) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (k == (int'(last_q) + i) % N_REQ && bus.req[k]) begin
                    pick_idx = IW'(k);
                end
            end
        end
        pick = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pick[k] = (IW'(k) == pick_idx);
        end
    end

    assign held = |(bus.req & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        stamp_d = stamp_q;
        err_d   = err_q;
        t_en_d  = 1'b0;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = pick;
                    last_d  = pick_idx;
                    t_en_d  = 1'b1;
                    state_d = EN;
                end
            end
            EN: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.t_valid) begin
                    stamp_d = bus.t_out;
                    err_d   = 1'b0;
                    ack_d   = gnt_q;
                    state_d = RESP;
                end else if (cnt_q == TMO) begin
                    stamp_d = '0;
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (!held) begin
                    ack_d   = '0;
                    gnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_1 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            stamp_q <= '0;
            err_q   <= 1'b0;
            t_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            stamp_q <= stamp_d;
            err_q   <= err_d;
            t_en_q  <= t_en_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.gnt   = gnt_q;
    assign bus.stamp = stamp_q;
    assign bus.err   = err_q;
    assign bus.t_en  = t_en_q;
    assign bus.busy  = busy_q;
endmodule
